// File: rtl/sa_aw_arbiter_pkg.sv
// Shared interconnect package for the AW-channel arbiter.
// Holds the arbiter FSM state encoding. Widths stay module parameters.
package sa_aw_arbiter_pkg;

    // IDLE: slave-side output slot empty.
    // BUSY: slot holds one request, s_AWVALID_o asserted.
    typedef enum logic {
        AW_IDLE = 1'b0,
        AW_BUSY = 1'b1
    } aw_state_e;

endpackage : sa_aw_arbiter_pkg

// File: rtl/sa_aw_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin selector.
//   req         in   N        request vector
//   last_grant  in   ID_W     index granted most recently
//   grant_idx   out  ID_W     winning index (valid when grant_vld)
//   grant_vld   out  1        at least one request present
// The search starts at last_grant+1 and wraps at N-1 -> 0. The scan is split
// into "above last_grant" and "at/below last_grant" halves so no modulo is
// needed and an out-of-range index can never be produced for non-power-of-2 N.
module rr_arbiter #(
    parameter int N    = 3,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_vld
);

    logic            hi_vld;
    logic            lo_vld;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        // Descending scan: the last hit in each half is its lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last_grant)) begin
                    hi_vld = 1'b1;
                    hi_idx = ID_W'(i);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = ID_W'(i);
                end
            end
        end
        grant_vld = hi_vld | lo_vld;
        grant_idx = hi_vld ? hi_idx : lo_idx;
    end

endmodule : rr_arbiter

// File: rtl/sa_aw_arbiter.sv
// sa_aw_arbiter: per-slave AW-channel arbiter between MST_AMT dispatchers.
// Ports:
//   ACLK_i, ARESET_i            clock, async active-high reset
//   dsp_AWADDR_i / dsp_AWLEN_i  packed per-master address / AxLEN
//   dsp_AWVALID_i, dsp_slv_sel_i per-master valid and "targets this slave"
//   dsp_AWREADY_o               per-master accept (one-hot or zero, combinational)
//   s_AWADDR_o/s_AWLEN_o/s_AWVALID_o, s_AWREADY_i  registered slave AW channel
//   AW_stall_i                  order FIFO full, blocks new grants
//   AW_mst_id_o/AW_AxLEN_o/AW_fifo_order_wr_en_o   order-FIFO push, same cycle as grant
// A grant loads the single output slot on the next edge; a grant may overlap
// a slave handshake so requests stream back-to-back without a bubble.
module sa_aw_arbiter
    import sa_aw_arbiter_pkg::*;
#(
    parameter int MST_AMT          = 3,
    parameter int MST_ID_W         = $clog2(MST_AMT),
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
) (
    input  logic                                  ACLK_i,
    input  logic                                  ARESET_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AWADDR_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AWLEN_i,
    input  logic [MST_AMT-1:0]                    dsp_AWVALID_i,
    input  logic [MST_AMT-1:0]                    dsp_slv_sel_i,
    output logic [MST_AMT-1:0]                    dsp_AWREADY_o,
    output logic [ADDR_WIDTH-1:0]                 s_AWADDR_o,
    output logic [TRANS_DATA_LEN_W-1:0]           s_AWLEN_o,
    output logic                                  s_AWVALID_o,
    input  logic                                  s_AWREADY_i,
    input  logic                                  AW_stall_i,
    output logic [MST_ID_W-1:0]                   AW_mst_id_o,
    output logic [TRANS_DATA_LEN_W-1:0]           AW_AxLEN_o,
    output logic                                  AW_fifo_order_wr_en_o
);

    // Unpacked per-master views of the flat request buses.
    logic [ADDR_WIDTH-1:0]       mst_addr [MST_AMT];
    logic [TRANS_DATA_LEN_W-1:0] mst_len  [MST_AMT];

    for (genvar k = 0; k < MST_AMT; k++) begin : g_unpack
        assign mst_addr[k] = dsp_AWADDR_i[ADDR_WIDTH*(k+1)-1 -: ADDR_WIDTH];
        assign mst_len[k]  = dsp_AWLEN_i[TRANS_DATA_LEN_W*(k+1)-1 -: TRANS_DATA_LEN_W];
    end

    aw_state_e           state;
    aw_state_e           state_nxt;
    logic [MST_ID_W-1:0] last_grant;
    logic [MST_AMT-1:0]  eligible;
    logic [MST_ID_W-1:0] rr_idx;
    logic                rr_vld;
    logic                slot_free;
    logic                grant;

    assign eligible = dsp_AWVALID_i & dsp_slv_sel_i;

    rr_arbiter #(
        .N    (MST_AMT),
        .ID_W (MST_ID_W)
    ) u_rr (
        .req        (eligible),
        .last_grant (last_grant),
        .grant_idx  (rr_idx),
        .grant_vld  (rr_vld)
    );

    // The slot can take a new request when empty or when its current
    // occupant is handed to the slave this very cycle.
    assign slot_free = (state == AW_IDLE) || (s_AWVALID_o && s_AWREADY_i);

    // ARESET_i gates the grant combinationally so nothing leaks out while
    // reset is held, independent of the inputs.
    assign grant = rr_vld && slot_free && !AW_stall_i && !ARESET_i;

    // Slot valid is a direct decode of the registered state.
    assign s_AWVALID_o = (state == AW_BUSY);

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            state <= AW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt             = state;
        dsp_AWREADY_o         = '0;
        AW_fifo_order_wr_en_o = grant;
        AW_mst_id_o           = rr_idx;
        AW_AxLEN_o            = mst_len[rr_idx];
        if (grant) begin
            dsp_AWREADY_o[rr_idx] = 1'b1;
        end
        unique case (state)
            AW_IDLE: begin
                if (grant) state_nxt = AW_BUSY;
            end
            AW_BUSY: begin
                // A grant refills the slot; a bare handshake empties it.
                if (!grant && s_AWREADY_i) state_nxt = AW_IDLE;
            end
            default: state_nxt = AW_IDLE;
        endcase
    end

    // Slot payload and round-robin pointer. Payload only changes on a grant,
    // which keeps it stable while the slave is back-pressuring.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            s_AWADDR_o <= '0;
            s_AWLEN_o  <= '0;
            last_grant <= MST_ID_W'(MST_AMT - 1);
        end else if (grant) begin
            s_AWADDR_o <= mst_addr[rr_idx];
            s_AWLEN_o  <= mst_len[rr_idx];
            last_grant <= rr_idx;
        end
    end

endmodule : sa_aw_arbiter
